// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache with a single-line refill engine.
//
// A hit returns the addressed word combinationally in the same cycle. A miss
// stalls fetch, latches the line address, requests the whole 4-word line from
// memory and, once it arrives, writes it into the line selected by the latched
// address. The access is then re-evaluated against whatever PC is presented.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   if_addr    fetch address (word addressed)
//   if_re      fetch request
//   if_instr   instruction word, valid when if_re=1 and if_stall=0, else 0
//   if_stall   fetch must hold its PC this cycle
//   flush      invalidate every line
//   mem_re     line read request, decoded from the FSM state
//   mem_addr   line address of the outstanding request
//   mem_rdata  returned line, word k in bits [16k+15:16k]
//   mem_rdy    single-cycle pulse marking mem_rdata valid
//   miss_cnt   saturating miss counter
module icache_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int LINES       = 8,
    parameter int WORDS       = 4,
    parameter int MEM_LAT_MAX = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_re,
    output logic [15:0]           if_instr,
    output logic                  if_stall,
    input  logic                  flush,
    output logic                  mem_re,
    output logic [ADDR_W-3:0]     mem_addr,
    input  logic [16*WORDS-1:0]   mem_rdata,
    input  logic                  mem_rdy,
    output logic [15:0]           miss_cnt
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - 2;
    localparam int LINE_W = 16 * WORDS;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t              state_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [LINE_W-1:0]   data_q [LINES];
    logic [ADDR_W-3:0]   mem_addr_q;
    logic [15:0]         miss_cnt_q;
    logic [15:0]         miss_cnt_d;

    logic [1:0]          off;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                hit;
    logic                miss;
    logic                fill;

    // Latency bound is informational only; the memory side is a pure handshake.
    logic unused_lat;
    assign unused_lat = (MEM_LAT_MAX != 0);

    assign off = if_addr[1:0];
    assign idx = if_addr[IDX_W+1:2];
    assign tag = if_addr[ADDR_W-1:IDX_W+2];

    // The fill target comes from the latched request, never from the live PC,
    // so the CPU may change if_addr while the refill is outstanding.
    assign fill_idx = mem_addr_q[IDX_W-1:0];
    assign fill_tag = mem_addr_q[ADDR_W-3:IDX_W];

    assign hit  = (state_q == IDLE) && if_re && valid_q[idx] && (tag_q[idx] == tag);
    assign miss = (state_q == IDLE) && if_re && !hit;
    assign fill = (state_q == FETCH) && mem_rdy;

    assign miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;

    assign if_stall = (state_q == FETCH) || miss;
    assign if_instr = hit ? data_q[idx][{off, 4'b0000} +: 16] : 16'h0000;
    assign mem_re   = (state_q == FETCH);
    assign mem_addr = mem_addr_q;
    assign miss_cnt = miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            mem_addr_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (miss) begin
                    state_q    <= FETCH;
                    mem_addr_q <= if_addr[ADDR_W-1:2];
                    miss_cnt_q <= miss_cnt_d;
                end
            end else begin
                if (mem_rdy) begin
                    state_q           <= IDLE;
                    valid_q[fill_idx] <= 1'b1;
                end
            end
            // Placed last so a flush coinciding with a fill also drops the new line.
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a line-level cache model.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] if_addr;
    logic        if_re;
    logic [15:0] if_instr;
    logic        if_stall;
    logic        flush;
    logic        mem_re;
    logic [13:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_rdy;
    logic [15:0] miss_cnt;

    icache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .if_addr   (if_addr),
        .if_re     (if_re),
        .if_instr  (if_instr),
        .if_stall  (if_stall),
        .flush     (flush),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each of the 8 slots remembers which full line address it holds.
    logic        m_valid [8];
    logic [13:0] m_line  [8];
    logic [63:0] m_data  [8];
    logic        m_pend;
    logic [13:0] m_pline;
    logic [15:0] m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_pend  = 1'b0;
        m_pline = 14'h0;
        m_cnt   = 16'h0;
    endtask

    function automatic logic m_hit();
        logic [2:0] ix;
        ix = if_addr[4:2];
        return !m_pend && if_re && m_valid[ix] && (m_line[ix] == if_addr[15:2]);
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        logic       h;
        logic [2:0] ix;
        if (!rst) return;
        h = m_hit();
        if (m_pend) begin
            if (mem_rdy) begin
                ix         = m_pline[2:0];
                m_line[ix] = m_pline;
                m_data[ix] = mem_rdata;
                m_valid[ix] = 1'b1;
                m_pend     = 1'b0;
            end
        end else if (if_re && !h) begin
            m_pend  = 1'b1;
            m_pline = if_addr[15:2];
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        if (flush) for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic compare_all();
        logic       h;
        logic       es;
        logic [15:0] ei;
        logic [2:0] ix;
        ix = if_addr[4:2];
        h  = m_hit();
        es = m_pend || (if_re && !h);
        ei = h ? m_data[ix][16*if_addr[1:0] +: 16] : 16'h0000;
        chk("if_stall", {63'b0, if_stall}, {63'b0, es});
        chk("if_instr", {48'b0, if_instr}, {48'b0, ei});
        chk("mem_re",   {63'b0, mem_re},   {63'b0, m_pend});
        chk("mem_addr", {50'b0, mem_addr}, {50'b0, m_pline});
        chk("miss_cnt", {48'b0, miss_cnt}, {48'b0, m_cnt});
    endtask

    task automatic cyc(input logic re, input logic [15:0] a, input logic fl,
                       input logic rdy, input logic [63:0] rd);
        @(posedge clk);
        model_step();
        #1;
        if_re = re; if_addr = a; flush = fl; mem_rdy = rdy; mem_rdata = rd;
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_pulse();
        if_re = 1'b0; flush = 1'b0; mem_rdy = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_mem_re",   {63'b0, mem_re},   64'h0);
        chk("rst_mem_addr", {50'b0, mem_addr}, 64'h0);
        chk("rst_miss_cnt", {48'b0, miss_cnt}, 64'h0);
        chk("rst_stall",    {63'b0, if_stall}, 64'h0);
        chk("rst_instr",    {48'b0, if_instr}, 64'h0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 64'h0);
        rst = 1'b1;
    endtask

    localparam logic [63:0] L0 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] L1 = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [63:0] L2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] L3 = 64'hFEDC_BA98_7654_3210;

    initial begin
        int          st_cnt;
        int          re_cnt;
        int          wait_ctr;
        logic        rdy;
        logic [15:0] exp_w [4];

        rst = 1'b0; if_addr = 16'h0; if_re = 1'b0; flush = 1'b0;
        mem_rdy = 1'b0; mem_rdata = 64'h0;
        model_reset();
        @(negedge clk);
        reset_pulse();

        // Cold miss at 0x0005, memory answers in the first FETCH cycle.
        cyc(1'b1, 16'h0005, 1'b0, 1'b0, 64'h0);
        chk("cold_stall1", {63'b0, if_stall}, 64'h1);
        cyc(1'b1, 16'h0005, 1'b0, 1'b1, L0);
        chk("cold_stall2", {63'b0, if_stall}, 64'h1);
        chk("cold_mem_re", {63'b0, mem_re}, 64'h1);
        chk("cold_mem_addr", {50'b0, mem_addr}, 64'h0001);
        cyc(1'b1, 16'h0005, 1'b0, 1'b0, 64'h0);
        chk("cold_hit_stall", {63'b0, if_stall}, 64'h0);
        chk("cold_hit_instr", {48'b0, if_instr}, 64'h2222);
        chk("cold_cnt", {48'b0, miss_cnt}, 64'h1);

        // Hit sweep across the filled line.
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 16'h0004 + 16'(k), 1'b0, 1'b0, 64'h0);
            chk("sweep_stall", {63'b0, if_stall}, 64'h0);
            chk("sweep_instr", {48'b0, if_instr}, {48'b0, exp_w[k]});
        end
        chk("sweep_cnt", {48'b0, miss_cnt}, 64'h1);

        // Flush in IDLE: this cycle still hits, the next one misses.
        cyc(1'b1, 16'h0004, 1'b1, 1'b0, 64'h0);
        chk("flush_same_stall", {63'b0, if_stall}, 64'h0);
        chk("flush_same_instr", {48'b0, if_instr}, 64'h1111);
        cyc(1'b1, 16'h0004, 1'b0, 1'b0, 64'h0);
        chk("flush_next_stall", {63'b0, if_stall}, 64'h1);

        // Flush together with mem_rdy: the fresh line is dropped, miss again.
        cyc(1'b1, 16'h0004, 1'b1, 1'b1, L1);
        cyc(1'b1, 16'h0004, 1'b0, 1'b0, 64'h0);
        chk("flush_rdy_stall", {63'b0, if_stall}, 64'h1);
        chk("flush_rdy_mem_re", {63'b0, mem_re}, 64'h0);
        cyc(1'b1, 16'h0004, 1'b0, 1'b1, L1);
        chk("flush_rdy_cnt", {48'b0, miss_cnt}, 64'h3);
        cyc(1'b1, 16'h0004, 1'b0, 1'b0, 64'h0);
        chk("flush_rdy_refill", {48'b0, if_instr}, 64'hAAAA);

        // Conflict on index 0 with a slow memory.
        reset_pulse();
        cyc(1'b1, 16'h0000, 1'b0, 1'b0, 64'h0);
        cyc(1'b1, 16'h0000, 1'b0, 1'b1, L2);
        cyc(1'b1, 16'h0000, 1'b0, 1'b0, 64'h0);
        chk("conf_hit0", {48'b0, if_instr}, 64'hCDEF);
        st_cnt = 0; re_cnt = 0;
        cyc(1'b1, 16'h0020, 1'b0, 1'b0, 64'h0);
        if (if_stall) st_cnt++;
        if (mem_re) re_cnt++;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 16'h0020, 1'b0, (k == 4), L3);
            if (if_stall) st_cnt++;
            if (mem_re) re_cnt++;
        end
        cyc(1'b1, 16'h0020, 1'b0, 1'b0, 64'h0);
        if (if_stall) st_cnt++;
        chk("conf_stall_cycles", 64'(st_cnt), 64'd6);
        chk("conf_mem_re_cycles", 64'(re_cnt), 64'd5);
        chk("conf_hit20", {48'b0, if_instr}, 64'h3210);
        cyc(1'b1, 16'h0000, 1'b0, 1'b0, 64'h0);
        chk("conf_remiss", {63'b0, if_stall}, 64'h1);
        cyc(1'b1, 16'h0000, 1'b0, 1'b1, L2);
        chk("conf_cnt", {48'b0, miss_cnt}, 64'h3);
        cyc(1'b1, 16'h0000, 1'b0, 1'b0, 64'h0);

        // Reset while a refill is outstanding.
        cyc(1'b1, 16'h0048, 1'b0, 1'b0, 64'h0);
        cyc(1'b1, 16'h0048, 1'b0, 1'b0, 64'h0);
        chk("midrst_pre_mem_re", {63'b0, mem_re}, 64'h1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_mem_re", {63'b0, mem_re}, 64'h0);
        chk("midrst_cnt", {48'b0, miss_cnt}, 64'h0);
        cyc(1'b0, 16'h0048, 1'b0, 1'b0, 64'h0);
        rst = 1'b1;
        cyc(1'b0, 16'h0048, 1'b0, 1'b1, L1);
        cyc(1'b1, 16'h0048, 1'b0, 1'b0, 64'h0);
        chk("midrst_stray_nohit", {63'b0, if_stall}, 64'h1);
        chk("midrst_cnt_after", {48'b0, miss_cnt}, 64'h0);

        // Randomized traffic: mixed PCs, random memory latency, stray mem_rdy,
        // occasional flushes.
        wait_ctr = 0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            model_step();
            #1;
            if_re   = ($urandom_range(0, 9) < 8);
            if_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
            flush   = ($urandom_range(0, 29) == 0);
            if (m_pend) begin
                if (wait_ctr == 0) begin
                    rdy = 1'b1;
                    wait_ctr = $urandom_range(0, 4);
                end else begin
                    rdy = 1'b0;
                    wait_ctr--;
                end
            end else begin
                rdy = ($urandom_range(0, 19) == 0);
            end
            mem_rdy   = rdy;
            mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            compare_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
